usr_burst: RTL

//   Parametrised universal shift register, next generation of the usr block.
//   - Eight per-cycle modes: hold, shift, rotate, arithmetic shift, load, clear.
//   - Self-timed burst engine: loads a word and shifts it out over exactly N

---
 rtl/usr_burst_pkg.sv | 38 +++
 rtl/usr_burst_ctrl.sv | 68 ++++++
 rtl/usr_burst.sv | 94 +++++++++
 3 files changed

// File: rtl/usr_burst_pkg.sv
// Shared encodings for the usr_burst universal shift register: mode codes,
// FSM states and the effective datapath operation chosen by the controller.
package usr_burst_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Low eight codes mirror the mode encodings; OP_START loads and arms a burst.
    typedef enum logic [3:0] {
        OP_HOLD  = 4'd0,
        OP_SHR   = 4'd1,
        OP_SHL   = 4'd2,
        OP_LOAD  = 4'd3,
        OP_ROR   = 4'd4,
        OP_ROL   = 4'd5,
        OP_ASR   = 4'd6,
        OP_CLR   = 4'd7,
        OP_START = 4'd8
    } op_e;

    function automatic op_e mode_to_op(input logic [MODE_W-1:0] mode);
        return op_e'({1'b0, mode});
    endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst controller: IDLE/BURST FSM, bit counter and busy/done generation.
// Emits the effective datapath operation for the current cycle.
module usr_burst_ctrl
    import usr_burst_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode,
    input  logic              start,
    input  logic              dir,
    output op_e               op_c,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               done_q;
    logic               done_d;

    // State, counter and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next state and effective operation; start outranks mode in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        op_c    = OP_HOLD;
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_BURST;
                cnt_d   = CNT_W'(N);
                op_c    = OP_START;
            end else begin
                op_c = mode_to_op(mode);
            end
        end else begin
            // dir was set from lsb_first at burst start and stays fixed
            op_c  = dir ? OP_SHL : OP_SHR;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    assign busy = (state_q == ST_BURST);
    assign done = done_q;

endmodule

// File: rtl/usr_burst.sv
// Parametrised universal shift register with a self-timed burst engine for
// full-duplex serialise/deserialise. Holds the data/dir registers and datapath.
module usr_burst
    import usr_burst_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode,
    input  logic              serial_in,
    input  logic [N-1:0]      parallel_in,
    input  logic              start,
    input  logic              lsb_first,
    output logic [N-1:0]      parallel_out,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    logic [N-1:0] data_q;
    logic [N-1:0] data_d;
    logic         dir_q;
    logic         dir_d;
    op_e          op_c;

    usr_burst_ctrl #(
        .N (N)
    ) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .start (start),
        .dir   (dir_q),
        .op_c  (op_c),
        .busy  (busy),
        .done  (done)
    );

    // Datapath: dir records which end feeds serial_out (1 = MSB side)
    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        case (op_c)
            OP_SHR: begin
                data_d = {serial_in, data_q[N-1:1]};
                dir_d  = 1'b0;
            end
            OP_SHL: begin
                data_d = {data_q[N-2:0], serial_in};
                dir_d  = 1'b1;
            end
            OP_LOAD: begin
                data_d = parallel_in;
            end
            OP_ROR: begin
                data_d = {data_q[0], data_q[N-1:1]};
                dir_d  = 1'b0;
            end
            OP_ROL: begin
                data_d = {data_q[N-2:0], data_q[N-1]};
                dir_d  = 1'b1;
            end
            OP_ASR: begin
                data_d = {data_q[N-1], data_q[N-1:1]};
                dir_d  = 1'b0;
            end
            OP_CLR: begin
                data_d = '0;
            end
            OP_START: begin
                data_d = parallel_in;
                dir_d  = ~lsb_first;
            end
            default: begin
                data_d = data_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            dir_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
        end
    end

    assign parallel_out = data_q;
    assign serial_out   = dir_q ? data_q[N-1] : data_q[0];

endmodule
